// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding and counter sizing.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Bit counter must index WIDTH bits but never collapse to zero width.
   function automatic int cnt_w(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/serial_adder_fa.sv
// 1-bit full adder cell; the only arithmetic element of the serial adder.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic cout,
   output logic sum
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: parallel operands in, LSB-first through one full_adder,
// parallel {cout, sum} out, valid/ready on both sides.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int            CW   = cnt_w(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state, state_nx;
   logic [WIDTH-1:0] a_sr, b_sr, sum_sr, sum_nx;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic             fa_sum, fa_cout;

   full_adder u_fa (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .cin  (carry),
      .cout (fa_cout),
      .sum  (fa_sum)
   );

   // New sum bit enters at the MSB so after WIDTH shifts bit 0 is the LSB.
   always_comb begin
      sum_nx          = sum_sr >> 1;
      sum_nx[WIDTH-1] = fa_sum;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = S_IDLE;
      case (state)
         S_IDLE: state_nx = in_valid ? S_RUN : S_IDLE;
         S_RUN:  state_nx = (cnt == LAST) ? S_DONE : S_RUN;
         S_DONE: state_nx = out_ready ? S_IDLE : S_DONE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sr   <= '0;
         b_sr   <= '0;
         sum_sr <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
      end else begin
         case (state)
            S_IDLE: if (in_valid) begin
               a_sr   <= a;
               b_sr   <= b;
               sum_sr <= '0;
               carry  <= cin;
               cnt    <= '0;
            end
            S_RUN: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               sum_sr <= sum_nx;
               carry  <= fa_cout;
               cnt    <= cnt + CW'(1);
            end
            default: ;
         endcase
      end
   end

   // Result is gated to DONE so a partial sum is never visible.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      sum       = '0;
      cout      = 1'b0;
      case (state)
         S_IDLE: in_ready = 1'b1;
         S_DONE: begin
            out_valid = 1'b1;
            sum       = sum_sr;
            cout      = carry;
         end
         default: ;
      endcase
   end

endmodule
